// File: rtl/hilo_muldiv_unit.sv
// ============================================================================
// Module   : hilo_muldiv_unit
// Purpose  : Iterative multiply/divide unit that owns the HI/LO registers.
//            Optional macro MDU_FAST_MULT_EN: single-cycle 32x32 multiply.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_muldiv_unit #(
  parameter int                DATA_W   = 32,
  parameter int                CNT_W    = 6,
  parameter logic [DATA_W-1:0] HILO_RST = 32'h0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic              hi_we,
  input  logic              lo_we,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int             ACC_W      = 2 * DATA_W;
  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, rs_q, rs_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d, dbz_q, dbz_d;

  // op[0] == 0 selects the signed variants; operands are stored as magnitudes.
  logic              w_rs_neg, w_rt_neg;
  logic [DATA_W-1:0] w_rs_mag, w_rt_mag;
  assign w_rs_neg = ~op[0] & read_data_1[DATA_W-1];
  assign w_rt_neg = ~op[0] & read_data_2[DATA_W-1];
  assign w_rs_mag = w_rs_neg ? -read_data_1 : read_data_1;
  assign w_rt_mag = w_rt_neg ? -read_data_2 : read_data_2;

  // Shift-add: acc = {partial product, remaining multiplier bits}.
  logic [DATA_W:0]   w_mul_sum;
  logic [ACC_W-1:0]  w_mul_step;
  assign w_mul_sum  = {1'b0, acc_q[ACC_W-1:DATA_W]}
                    + (acc_q[0] ? {1'b0, a_q} : {(DATA_W+1){1'b0}});
  assign w_mul_step = {w_mul_sum, acc_q[DATA_W-1:1]};

  // Restoring divide: acc = {partial remainder, dividend/quotient bits}.
  logic [DATA_W:0]   w_div_trial, w_div_diff;
  logic [ACC_W-1:0]  w_div_step;
  assign w_div_trial = acc_q[ACC_W-1:DATA_W-1];
  assign w_div_diff  = w_div_trial - {1'b0, b_q};
  assign w_div_step  = w_div_diff[DATA_W]
                     ? {w_div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                     : {w_div_diff[DATA_W-1:0],  acc_q[DATA_W-2:0], 1'b1};

  logic [ACC_W-1:0]  w_prod_fix;
  logic [DATA_W-1:0] w_quot_fix, w_rem_fix;
  assign w_prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign w_quot_fix = (sa_q ^ sb_q) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign w_rem_fix  = sa_q ? -acc_q[ACC_W-1:DATA_W] : acc_q[ACC_W-1:DATA_W];

`ifdef MDU_FAST_MULT_EN
  logic [ACC_W-1:0]  w_fast_prod;
  assign w_fast_prod = {{DATA_W{1'b0}}, w_rs_mag} * {{DATA_W{1'b0}}, w_rt_mag};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    rs_d    = rs_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          a_d   = w_rs_mag;
          b_d   = w_rt_mag;
          sa_d  = w_rs_neg;
          sb_d  = w_rt_neg;
          rs_d  = read_data_1;
          cnt_d = '0;
`ifdef MDU_FAST_MULT_EN
          if (!op[1]) begin
            acc_d   = w_fast_prod;
            state_d = S_FIX;
          end else begin
            acc_d   = {{DATA_W{1'b0}}, w_rs_mag};
            state_d = S_CALC;
          end
`else
          acc_d   = op[1] ? {{DATA_W{1'b0}}, w_rs_mag} : {{DATA_W{1'b0}}, w_rt_mag};
          state_d = S_CALC;
`endif
        end else begin
          if (hi_we) hi_d = read_data_1;
          if (lo_we) lo_d = read_data_1;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = op_q[1] ? w_div_step : w_mul_step;
        if (cnt_q == c_last_iter) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          {hi_d, lo_d} = w_prod_fix;
        end else if (b_q == '0) begin
          hi_d  = rs_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = w_rem_fix;
          lo_d = w_quot_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      rs_q    <= '0;
      acc_q   <= '0;
      hi_q    <= HILO_RST;
      lo_q    <= HILO_RST;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      rs_q    <= rs_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
// ============================================================================
// Module   : tb_hilo_muldiv_unit
// Purpose  : Directed self-checking bench for hilo_muldiv_unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hilo_muldiv_unit;

  localparam logic [1:0] c_mult  = 2'b00;
  localparam logic [1:0] c_multu = 2'b01;
  localparam logic [1:0] c_div   = 2'b10;
  localparam logic [1:0] c_divu  = 2'b11;
  localparam int         c_div_lat = 34;
`ifdef MDU_FAST_MULT_EN
  localparam int         c_mul_lat = 2;
`else
  localparam int         c_mul_lat = 34;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] read_data_1, read_data_2;
  logic        hi_we, lo_we;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_unit dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive start for one edge (T0); returns with the edge count so far.
  task automatic launch(input logic [1:0] o, input logic [31:0] rs, input logic [31:0] rt,
                        output int n);
    start = 1'b1; op = o; read_data_1 = rs; read_data_2 = rt;
    tick();
    start = 1'b0;
    n = 1;
  endtask

  // Waits for done (bounded) and checks latency and results in the done cycle.
  task automatic finish_op(input string tag, input int n_in, input int exp_lat,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    int n = n_in;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_hi"}, 64'(hi), 64'(ehi));
    check({tag, "_lo"}, 64'(lo), 64'(elo));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
    check({tag, "_busy_end"}, 64'(busy), 64'h0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] rs,
                        input logic [31:0] rt, input int exp_lat,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    int n;
    launch(o, rs, rt, n);
    check({tag, "_busy"}, 64'(busy), 64'h1);
    finish_op(tag, n, exp_lat, ehi, elo, edbz);
    tick();
    check({tag, "_done_fall"}, 64'({done, div_by_zero}), 64'h0);
  endtask

  initial begin
    int n;
    bit seen_done;
    reset = 1'b0; start = 1'b0; op = 2'b00;
    read_data_1 = '0; read_data_2 = '0; hi_we = 1'b0; lo_we = 1'b0;
    tick(); tick();
    reset = 1'b1;
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_dbz", 64'(div_by_zero), 64'h0);
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);

    // MTHI and MTLO together in IDLE.
    hi_we = 1'b1; lo_we = 1'b1; read_data_1 = 32'h1234_5678;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("mt_both_hi", 64'(hi), 64'h1234_5678);
    check("mt_both_lo", 64'(lo), 64'h1234_5678);

    // Asynchronous reset in the middle of an operation.
    launch(c_divu, 32'd100, 32'd7, n);
    repeat (9) tick();
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'h0);
    check("arst_done", 64'(done), 64'h0);
    check("arst_hi", 64'(hi), 64'h0);
    check("arst_lo", 64'(lo), 64'h0);
    tick();
    reset = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    check("arst_no_done", 64'(seen_done), 64'h0);

    run_op("multu_max", c_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c_mul_lat,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg", c_mult, 32'hFFFF_FFF9, 32'd3, c_mul_lat,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_negneg", c_mult, 32'hFFFF_FFFE, 32'hFFFF_FFFD, c_mul_lat,
           32'h0000_0000, 32'h0000_0006, 1'b0);
    run_op("div_neg", c_div, 32'hFFFF_FFF9, 32'd2, c_div_lat,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu", c_divu, 32'd100, 32'd7, c_div_lat, 32'd2, 32'd14, 1'b0);
    run_op("div_zero", c_div, 32'd5, 32'd0, c_div_lat, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("divu_zero", c_divu, 32'hF000_0009, 32'd0, c_div_lat,
           32'hF000_0009, 32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf", c_div, 32'h8000_0000, 32'hFFFF_FFFF, c_div_lat,
           32'h0000_0000, 32'h8000_0000, 1'b0);

    // start / MTHI / MTLO while busy are ignored.
    launch(c_divu, 32'd100, 32'd7, n);
    repeat (3) begin tick(); n++; end
    start = 1'b1; op = c_multu; hi_we = 1'b1; lo_we = 1'b1;
    read_data_1 = 32'hDEAD_BEEF; read_data_2 = 32'd3;
    tick(); n++;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("busy_mt_hi", 64'(hi), 64'h0);
    check("busy_mt_lo", 64'(lo), 64'h8000_0000);
    finish_op("busy_ign", n, c_div_lat, 32'd2, 32'd14, 1'b0);
    tick();

    // MTHI in IDLE writes HI only.
    hi_we = 1'b1; read_data_1 = 32'hCAFE_F00D;
    tick();
    hi_we = 1'b0;
    check("mthi_hi", 64'(hi), 64'hCAFE_F00D);
    check("mthi_lo", 64'(lo), 64'd14);

    // start together with MTHI: the move is dropped.
    hi_we = 1'b1;
    launch(c_divu, 32'd50, 32'd5, n);
    hi_we = 1'b0;
    check("start_mt_hi", 64'(hi), 64'hCAFE_F00D);
    finish_op("start_mt", n, c_div_lat, 32'd0, 32'd10, 1'b0);

    // MTLO in the done cycle is accepted.
    lo_we = 1'b1; read_data_1 = 32'h0000_0077;
    tick();
    lo_we = 1'b0;
    check("mtlo_done_lo", 64'(lo), 64'h77);
    check("mtlo_done_hi", 64'(hi), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
